// File: rtl/psc_trigger_pkg.sv
// Shared constants, FSM state type and CRC-8 helper
// for the multi-channel PSC trigger transmitter.
package psc_trigger_pkg;

    localparam logic [7:0] SOP_DEF        = 8'h3C;
    localparam logic [7:0] EOP_DEF        = 8'hBC;
    localparam logic [7:0] TYPE_IDLE      = 8'h00;
    localparam logic [7:0] TYPE_TRIG_FLAG = 8'h80;
    localparam logic [7:0] CRC8_POLY      = 8'h07;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    function automatic logic [7:0] crc8_update(
        input logic [7:0] crc,
        input logic [7:0] data
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY)
                     : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/psc_trigger_tx_mc_if.sv
// Control/status bundle of the trigger transmitter;
// master drives the trigger inputs, slave is the transmitter.
interface psc_trigger_tx_mc_if #(
    parameter int CHANNELS = 4
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                enable;
    logic [CHANNELS-1:0] trig_in;
    logic [CHANNELS-1:0] ch_mask;
    logic                overrun_clr;
    logic                tx_out;
    logic                frame_start;
    logic                trig_sent;
    logic [CH_W-1:0]     trig_ch;
    logic [7:0]          seq;
    logic [CHANNELS-1:0] overrun;

    modport master (
        output enable, trig_in, ch_mask, overrun_clr,
        input  tx_out, frame_start, trig_sent,
        input  trig_ch, seq, overrun
    );

    modport slave (
        input  enable, trig_in, ch_mask, overrun_clr,
        output tx_out, frame_start, trig_sent,
        output trig_ch, seq, overrun
    );
endinterface

// File: rtl/psc_symbol_serializer.sv
// Emits one byte as a 10-bit symbol: start 0,
// 8 data bits LSB first, stop 1; advances on bit ticks.
module psc_symbol_serializer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_tick,
    output logic       o_bit,
    output logic       o_done
);
    logic [7:0] r_byte;
    logic [3:0] r_idx;
    logic [3:0] w_di;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte <= 8'h00;
            r_idx  <= 4'd0;
        end else if (i_load) begin
            r_byte <= i_byte;
            r_idx  <= 4'd0;
        end else if (i_tick) begin
            r_idx <= (r_idx == 4'd9) ? 4'd0 : r_idx + 4'd1;
        end
    end

    assign w_di   = r_idx - 4'd1;
    assign o_done = i_tick & (r_idx == 4'd9);

    always_comb begin
        o_bit = 1'b1;
        unique case (1'b1)
            (r_idx == 4'd0): o_bit = 1'b0;
            (r_idx == 4'd9): o_bit = 1'b1;
            default:         o_bit = r_byte[w_di[2:0]];
        endcase
    end
endmodule

// File: rtl/psc_trigger_tx_mc.sv
// Multi-channel PSC trigger transmitter: input sync and edge
// capture, lowest-index arbiter, frame FSM, byte mux and CRC-8.
module psc_trigger_tx_mc
    import psc_trigger_pkg::*;
#(
    parameter int         CHANNELS    = 4,
    parameter int         CLK_DIV     = 5,
    parameter int         FRAME_BYTES = 6,
    parameter logic [7:0] SOP         = SOP_DEF,
    parameter logic [7:0] EOP         = EOP_DEF
) (
    input logic              clk,
    input logic              reset,
    psc_trigger_tx_mc_if.slave bus
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW   = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [7:0] LAST_B  = 8'(FRAME_BYTES - 1);
    localparam logic [7:0] CRC_B   = 8'(FRAME_BYTES - 2);
    localparam logic [7:0] PAD_END = 8'(FRAME_BYTES - 3);

    state_t r_state, w_next;

    logic [CHANNELS-1:0] r_s1, r_s2, r_s3;
    logic [CHANNELS-1:0] r_pend, r_ovr;
    logic [CHANNELS-1:0] w_edge, w_gnt, w_clr;
    logic [CH_W-1:0]     w_gidx, r_ch;
    logic [DW-1:0]       r_div;
    logic [7:0]          r_idx, r_crc, r_seq;
    logic [7:0]          w_nidx, w_nbyte;
    logic                r_trig_frm, r_fs, r_ts;
    logic                w_any, w_tick, w_bit, w_done, w_ld;
    logic                w_in_load, w_in_shift;

    psc_symbol_serializer u_ser (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_ld),
        .i_byte (w_nbyte),
        .i_tick (w_tick),
        .o_bit  (w_bit),
        .o_done (w_done)
    );

    // Input path: 2-flop sync plus one delay stage for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= bus.trig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_s3 & bus.ch_mask;

    always_comb begin
        w_gnt  = '0;
        w_gidx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_gnt    = '0;
                w_gnt[i] = 1'b1;
                w_gidx   = CH_W'(i);
            end
        end
    end

    assign w_any = |r_pend;
    assign w_clr = w_in_load ? w_gnt : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
            r_ovr  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_edge;
            r_ovr  <= (bus.overrun_clr ? '0 : r_ovr)
                    | (w_edge & r_pend & ~w_clr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_OFF;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_OFF:   if (bus.enable) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_SHIFT;
            ST_SHIFT: if (w_done && r_idx == LAST_B)
                          w_next = bus.enable ? ST_LOAD : ST_OFF;
            default:  w_next = ST_OFF;
        endcase
    end

    always_comb begin
        w_in_load   = 1'b0;
        w_in_shift  = 1'b0;
        unique case (r_state)
            ST_LOAD:  w_in_load  = 1'b1;
            ST_SHIFT: w_in_shift = 1'b1;
            default:  ;
        endcase
        bus.tx_out = w_in_shift ? w_bit : 1'b1;
    end

    assign w_tick = w_in_shift & (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  r_div <= '0;
        else if (w_in_shift && !w_tick) r_div <= r_div + 1'b1;
        else                         r_div <= '0;
    end

    assign w_nidx = w_in_load ? 8'd0 : r_idx + 8'd1;
    assign w_ld   = w_in_load | (w_done & (r_idx != LAST_B));

    always_comb begin
        w_nbyte = 8'h00;
        unique case (1'b1)
            (w_nidx == 8'd0): w_nbyte = SOP;
            (w_nidx == 8'd1): w_nbyte = r_trig_frm
                ? (TYPE_TRIG_FLAG | 8'(r_ch)) : TYPE_IDLE;
            (w_nidx == 8'd2): w_nbyte = r_trig_frm ? r_seq : 8'h00;
            (w_nidx == CRC_B):  w_nbyte = r_crc;
            (w_nidx == LAST_B): w_nbyte = EOP;
            default:          w_nbyte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx      <= 8'd0;
            r_crc      <= 8'h00;
            r_seq      <= 8'h00;
            r_ch       <= '0;
            r_trig_frm <= 1'b0;
            r_fs       <= 1'b0;
            r_ts       <= 1'b0;
        end else begin
            r_fs <= w_in_load;
            r_ts <= w_in_load & w_any;
            if (w_in_load) begin
                r_idx      <= 8'd0;
                r_crc      <= 8'h00;
                r_trig_frm <= w_any;
                if (w_any) begin
                    r_seq <= r_seq + 8'd1;
                    r_ch  <= w_gidx;
                end
            end else if (w_ld) begin
                r_idx <= w_nidx;
                // CRC covers TYPE through the last pad byte
                if (w_nidx >= 8'd1 && w_nidx <= PAD_END)
                    r_crc <= crc8_update(r_crc, w_nbyte);
            end
        end
    end

    assign bus.frame_start = r_fs;
    assign bus.trig_sent   = r_ts;
    assign bus.trig_ch     = r_ch;
    assign bus.seq         = r_seq;
    assign bus.overrun     = r_ovr;
endmodule
